park_seq: RTL



---
 rtl/park_pkg.sv | 24 ++
 rtl/park_sat_trunc.sv | 42 ++++
 rtl/park_seq.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/park_pkg.sv
// park_pkg: shared types and constants for the Park transform stage.
// Revision: 1.0
`default_nettype none

package park_pkg;

    localparam int PARK_D_WIDTH = 18;
    localparam int PARK_Q_BITS  = 15;
    localparam int PROD_WIDTH   = 2 * PARK_D_WIDTH;
    localparam int ACC_WIDTH    = 2 * PARK_D_WIDTH + 1;
    localparam int ONE_Q        = 2 ** PARK_Q_BITS;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_M0   = 3'd1,
        ST_M1   = 3'd2,
        ST_M2   = 3'd3,
        ST_M3   = 3'd4,
        ST_OUT  = 3'd5
    } park_state_e;

endpackage

`default_nettype wire

// File: rtl/park_sat_trunc.sv
// park_sat_trunc: arithmetic shift by Q_BITS, then reduce to D_WIDTH.
// Build macro PARK_SAT_EN selects saturation; otherwise two's-complement wrap.
`default_nettype none

module park_sat_trunc #(
    parameter int D_WIDTH = 18,
    parameter int Q_BITS  = 15
) (
    input  logic signed [2*D_WIDTH:0]  acc_i,
    output logic signed [D_WIDTH-1:0]  res_o
);

    localparam int ACC_W = 2 * D_WIDTH + 1;

    logic signed [ACC_W-1:0] shifted;

    assign shifted = acc_i >>> Q_BITS;

`ifdef PARK_SAT_EN
    localparam logic signed [ACC_W-1:0] MAX_V =
        {{(ACC_W-D_WIDTH+1){1'b0}}, {(D_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V =
        {{(ACC_W-D_WIDTH+1){1'b1}}, {(D_WIDTH-1){1'b0}}};

    always_comb begin
        res_o = shifted[D_WIDTH-1:0];
        if (shifted > MAX_V) begin
            res_o = MAX_V[D_WIDTH-1:0];
        end else if (shifted < MIN_V) begin
            res_o = MIN_V[D_WIDTH-1:0];
        end
    end
`else
    logic unused_hi;

    assign unused_hi = ^shifted[ACC_W-1:D_WIDTH];
    assign res_o     = shifted[D_WIDTH-1:0];
`endif

endmodule

`default_nettype wire

// File: rtl/park_seq.sv
// park_seq: multi-cycle Park transform (d/q from alpha/beta, sin/cos) on one shared multiplier.
// Build macro PARK_SAT_EN: saturate d/q instead of wrapping.
`default_nettype none

module park_seq
    import park_pkg::*;
#(
    parameter int D_WIDTH = PARK_D_WIDTH,
    parameter int Q_BITS  = PARK_Q_BITS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic signed [D_WIDTH-1:0] alpha,
    input  logic signed [D_WIDTH-1:0] beta,
    input  logic signed [D_WIDTH-1:0] sin_theta,
    input  logic signed [D_WIDTH-1:0] cos_theta,
    input  logic                      start,
    output logic                      busy,
    output logic signed [D_WIDTH-1:0] d,
    output logic signed [D_WIDTH-1:0] q,
    output logic                      done
);

    localparam int PROD_W = 2 * D_WIDTH;
    localparam int ACC_W  = 2 * D_WIDTH + 1;

    park_state_e state_q, state_d;

    logic signed [D_WIDTH-1:0] alpha_q, alpha_d;
    logic signed [D_WIDTH-1:0] beta_q,  beta_d;
    logic signed [D_WIDTH-1:0] sin_q,   sin_d;
    logic signed [D_WIDTH-1:0] cos_q,   cos_d;
    logic signed [ACC_W-1:0]   accd_q,  accd_d;
    logic signed [ACC_W-1:0]   accq_q,  accq_d;
    logic signed [D_WIDTH-1:0] dout_q,  dout_d;
    logic signed [D_WIDTH-1:0] qout_q,  qout_d;
    logic                      done_q,  done_d;

    logic signed [D_WIDTH-1:0] mul_a, mul_b;
    logic signed [PROD_W-1:0]  prod;
    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [D_WIDTH-1:0] d_red, q_red;

    // Operand steering for the single shared multiplier.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state_q)
            ST_M0: begin mul_a = alpha_q; mul_b = cos_q; end
            ST_M1: begin mul_a = beta_q;  mul_b = sin_q; end
            ST_M2: begin mul_a = beta_q;  mul_b = cos_q; end
            ST_M3: begin mul_a = alpha_q; mul_b = sin_q; end
            default: ;
        endcase
    end

    assign prod     = mul_a * mul_b;
    assign prod_ext = $signed({prod[PROD_W-1], prod});

    park_sat_trunc #(.D_WIDTH(D_WIDTH), .Q_BITS(Q_BITS)) u_red_d (
        .acc_i (accd_q),
        .res_o (d_red)
    );

    park_sat_trunc #(.D_WIDTH(D_WIDTH), .Q_BITS(Q_BITS)) u_red_q (
        .acc_i (accq_q),
        .res_o (q_red)
    );

    always_comb begin
        state_d = state_q;
        alpha_d = alpha_q;
        beta_d  = beta_q;
        sin_d   = sin_q;
        cos_d   = cos_q;
        accd_d  = accd_q;
        accq_d  = accq_q;
        dout_d  = dout_q;
        qout_d  = qout_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    alpha_d = alpha;
                    beta_d  = beta;
                    sin_d   = sin_theta;
                    cos_d   = cos_theta;
                    state_d = ST_M0;
                end
            end
            ST_M0: begin
                accd_d  = prod_ext;
                state_d = ST_M1;
            end
            ST_M1: begin
                accd_d  = accd_q + prod_ext;
                state_d = ST_M2;
            end
            ST_M2: begin
                accq_d  = prod_ext;
                state_d = ST_M3;
            end
            ST_M3: begin
                accq_d  = accq_q - prod_ext;
                state_d = ST_OUT;
            end
            ST_OUT: begin
                dout_d  = d_red;
                qout_d  = q_red;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            alpha_q <= '0;
            beta_q  <= '0;
            sin_q   <= '0;
            cos_q   <= '0;
            accd_q  <= '0;
            accq_q  <= '0;
            dout_q  <= '0;
            qout_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            alpha_q <= alpha_d;
            beta_q  <= beta_d;
            sin_q   <= sin_d;
            cos_q   <= cos_d;
            accd_q  <= accd_d;
            accq_q  <= accq_d;
            dout_q  <= dout_d;
            qout_q  <= qout_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign d    = dout_q;
    assign q    = qout_q;
    assign done = done_q;

endmodule

`default_nettype wire
